bch_error_correct: RTL and testbench

//  Downstream of the error locator (chien-search decoder): buffers received message bits while syndromes
//  and error search run, then XORs each buffered bit with the decoder's per-cycle err flag.

---
 rtl/bch_error_correct.sv | 126 ++++++++++++
 tb/tb_bch_error_correct.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bch_error_correct.sv
// bch_error_correct: buffers message bits, XORs with decoder err flags, streams corrected bits (stats via BCH_CORRECT_STATS_EN)
module bch_error_correct #(
  parameter int DATA_BITS = 16,
  parameter int CW_DEPTH  = 2,
  parameter int T         = 2,
  parameter int ERR_W     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_data,
  input  logic             dec_valid,
  input  logic             dec_first,
  input  logic             dec_last,
  input  logic             dec_err,
  input  logic [ERR_W-1:0] dec_err_count,
  output logic             dec_accepted,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_data,
  output logic             out_first,
  output logic             out_last,
  output logic             out_fail,
  output logic             misalign,
  output logic [15:0]      corr_bits,
  output logic [15:0]      fail_cws
);
  localparam int DEPTH = DATA_BITS * CW_DEPTH;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int FW    = $clog2(DEPTH + 1);
  localparam int CW    = $clog2(CW_DEPTH + 1);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [BW-1:0]    wr_bit, rd_bit;
  logic [FW-1:0]    free_cnt;
  logic [CW-1:0]    cw_full;
  logic             wr_en, wr_done, rd_last_pos, rd_done, uncorr, bad_frame;

  assign in_ready     = free_cnt != '0;
  assign wr_en        = in_valid && in_ready;
  assign wr_done      = wr_en && wr_bit == BW'(DATA_BITS - 1);
  assign dec_accepted = dec_valid && cw_full != '0 && (!out_valid || out_ready);
  assign rd_last_pos  = rd_bit == BW'(DATA_BITS - 1);
  assign rd_done      = dec_accepted && rd_last_pos;
  assign uncorr       = int'(dec_err_count) > T;
  assign bad_frame    = (dec_first != (rd_bit == '0)) || (dec_last != rd_last_pos);

  // bit storage; stale contents are never read because cw_full gates every read
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= in_data;

  // write side: pointer, position within codeword
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      wr_bit <= '0;
    end else if (wr_en) begin
      wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      wr_bit <= (wr_bit == BW'(DATA_BITS - 1)) ? '0 : wr_bit + 1'b1;
    end

  // read side: pointer, position within codeword
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr <= '0;
      rd_bit <= '0;
    end else if (dec_accepted) begin
      rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      rd_bit <= rd_last_pos ? '0 : rd_bit + 1'b1;
    end

  // occupancy: slots return only when a whole codeword has been read out
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      free_cnt <= FW'(DEPTH);
      cw_full  <= '0;
    end else begin
      free_cnt <= free_cnt - FW'(wr_en) + (rd_done ? FW'(DATA_BITS) : '0);
      cw_full  <= cw_full + CW'(wr_done) - CW'(rd_done);
    end

  // output register: load on accept, hold under stall, clear once drained
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_fail  <= 1'b0;
    end else if (dec_accepted) begin
      out_valid <= 1'b1;
      out_data  <= mem[rd_ptr] ^ dec_err;
      out_first <= dec_first;
      out_last  <= dec_last;
      out_fail  <= dec_last && uncorr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_data  <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_fail  <= 1'b0;
    end

  // sticky framing error: decoder first/last must line up with buffer codeword boundaries
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) misalign <= 1'b0;
    else if (dec_accepted && bad_frame) misalign <= 1'b1;

`ifdef BCH_CORRECT_STATS_EN
  // saturating count of corrected bits
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) corr_bits <= '0;
    else if (dec_accepted && dec_err && corr_bits != 16'hFFFF) corr_bits <= corr_bits + 1'b1;

  // saturating count of uncorrectable codewords
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fail_cws <= '0;
    else if (dec_accepted && dec_last && uncorr && fail_cws != 16'hFFFF) fail_cws <= fail_cws + 1'b1;
`else
  assign corr_bits = '0;
  assign fail_cws  = '0;
`endif
endmodule

// File: tb/tb_bch_error_correct.sv
// tb_bch_error_correct: directed checks of buffering, correction, framing, back-pressure and reset
module tb_bch_error_correct;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_data = 1'b0, in_ready;
  logic dec_valid = 1'b0, dec_first = 1'b0, dec_last = 1'b0, dec_err = 1'b0;
  logic [1:0] dec_err_count = '0;
  logic dec_accepted, out_valid, out_data, out_first, out_last, out_fail, misalign;
  logic out_ready = 1'b0;
  logic [15:0] corr_bits, fail_cws;
  int n_chk = 0, n_fail = 0;

`ifdef BCH_CORRECT_STATS_EN
  localparam logic [15:0] EXP_CORR = 16'd2, EXP_FAILS = 16'd1;
`else
  localparam logic [15:0] EXP_CORR = 16'd0, EXP_FAILS = 16'd0;
`endif

  bch_error_correct dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dec_valid(dec_valid), .dec_first(dec_first), .dec_last(dec_last),
    .dec_err(dec_err), .dec_err_count(dec_err_count), .dec_accepted(dec_accepted),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_first(out_first), .out_last(out_last), .out_fail(out_fail),
    .misalign(misalign), .corr_bits(corr_bits), .fail_cws(fail_cws)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cw(input logic [15:0] d);
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = d[i];
      #1;
      chk("wr_ready", in_ready, 1);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic read_cw(input logic [15:0] exp, input logic [15:0] m, input logic [1:0] cnt);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      dec_valid = 1'b1;
      dec_first = (i == 0);
      dec_last = (i == 15);
      dec_err = m[i];
      dec_err_count = cnt;
      #1;
      chk("rd_acc", dec_accepted, 1);
      step();
      chk("rd_ov", out_valid, 1);
      chk("rd_data", out_data, exp[i]);
      chk("rd_first", out_first, i == 0);
      chk("rd_last", out_last, i == 15);
      chk("rd_fail", out_fail, (i == 15) && cnt > 2);
    end
    dec_valid = 1'b0;
    dec_first = 1'b0;
    dec_last = 1'b0;
    dec_err = 1'b0;
    step();
    chk("rd_ov_clr", out_valid, 0);
  endtask

  initial begin
    logic [15:0] d4, e4, m4;
    int j, got, cyc;
    logic mov, exp_acc;
    #12;
    chk("rst_ready", in_ready, 1);
    chk("rst_ov", out_valid, 0);
    chk("rst_acc", dec_accepted, 0);
    chk("rst_mis", misalign, 0);
    rst_n = 1'b1;
    step();
    // 1: two correctable errors
    write_cw(16'hA5A5);
    read_cw(16'hA7AD, 16'h0208, 2'd2);
    // 2: uncorrectable count, no flagged bits
    write_cw(16'h3C5A);
    read_cw(16'h3C5A, 16'h0000, 2'd3);
    chk("corr_bits", corr_bits, EXP_CORR);
    chk("fail_cws", fail_cws, EXP_FAILS);
    chk("mis_clean", misalign, 0);
    // 3: fill both codewords, overflow attempt, reopen
    write_cw(16'h1234);
    write_cw(16'hBEEF);
    in_valid = 1'b1;
    in_data = 1'b1;
    #1;
    chk("full_ready", in_ready, 0);
    step();
    chk("full_ready2", in_ready, 0);
    in_valid = 1'b0;
    read_cw(16'h1234, 16'h0000, 2'd0);
    chk("reopen_ready", in_ready, 1);
    write_cw(16'h0F0F);
    chk("refull_ready", in_ready, 0);
    // 4: toggling sink on codeword 0xBEEF, errors at bits 0 and 5
    d4 = 16'hBECE;
    m4 = 16'h0021;
    e4 = d4;
    j = 0;
    got = 0;
    cyc = 0;
    mov = 1'b0;
    while (got < 16 && cyc < 100) begin
      out_ready = cyc[0];
      dec_valid = (j < 16);
      dec_first = (j == 0);
      dec_last = (j == 15);
      dec_err = (j < 16) ? m4[j[3:0]] : 1'b0;
      dec_err_count = 2'd1;
      #1;
      exp_acc = (j < 16) && (!mov || out_ready);
      chk("tog_acc", dec_accepted, exp_acc);
      if (mov && out_ready) begin
        chk("tog_data", out_data, e4[got[3:0]]);
        chk("tog_first", out_first, got == 0);
        chk("tog_last", out_last, got == 15);
        got++;
      end
      step();
      if (exp_acc) begin
        mov = 1'b1;
        j++;
      end else if (out_ready) mov = 1'b0;
      chk("tog_ov", out_valid, mov);
      cyc++;
    end
    chk("tog_done", got, 16);
    dec_valid = 1'b0;
    dec_first = 1'b0;
    dec_last = 1'b0;
    dec_err = 1'b0;
    out_ready = 1'b1;
    step();
    read_cw(16'h8F0F, 16'h8000, 2'd1);
    // 5: decoder early, must wait for the 16th write
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = i[0];
      if (i >= 10) begin
        dec_valid = 1'b1;
        dec_first = 1'b1;
      end
      #1;
      chk("early_acc", dec_accepted, 0);
      step();
    end
    in_valid = 1'b0;
    read_cw(16'hAAAA, 16'h0000, 2'd0);
    chk("mis_early", misalign, 0);
    // 6: early dec_last sets sticky misalign, then async reset mid-stream
    write_cw(16'h5555);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      dec_valid = 1'b1;
      dec_first = (i == 0);
      dec_last = (i == 14);
      dec_err = 1'b0;
      dec_err_count = 2'd0;
      step();
      chk("mis_data", out_data, i % 2 == 0);
      if (i >= 14) chk("mis_set", misalign, 1);
      else chk("mis_pre", misalign, 0);
    end
    dec_valid = 1'b0;
    dec_last = 1'b0;
    step();
    step();
    chk("mis_sticky", misalign, 1);
    write_cw(16'hFFFF);
    for (int i = 0; i < 5; i++) begin
      dec_valid = 1'b1;
      dec_first = (i == 0);
      dec_err = 1'b1;
      step();
    end
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", in_ready, 1);
    chk("mrst_ov", out_valid, 0);
    chk("mrst_data", out_data, 0);
    chk("mrst_first", out_first, 0);
    chk("mrst_last", out_last, 0);
    chk("mrst_fail", out_fail, 0);
    chk("mrst_mis", misalign, 0);
    chk("mrst_acc", dec_accepted, 0);
    chk("mrst_corr", corr_bits, 0);
    chk("mrst_fcw", fail_cws, 0);
    dec_valid = 1'b0;
    dec_first = 1'b0;
    dec_err = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_ready", in_ready, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
